// File: rtl/status_flag_blk.sv
// Status-bit transfer block: moves a single rdata status bit to the master
// over a valid/master_ready handshake, counts completed transfers, and flags
// slave-side protocol violations while an offer is stalled.
//
// Handshake semantics: a transfer completes on a rising edge where
// valid=1 and master_ready=1. Once valid is raised against master_ready=0,
// the slave must hold valid high and rdata stable until the transfer
// completes. Dropping valid or changing rdata during the stall is a
// violation and sets the sticky proto_err flag.
module status_flag_blk #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdata,
  input  logic             master_ready,
  input  logic             valid,
  input  logic             err_clr,
  output logic             sin,
  output logic             xfer,
  output logic             pending,
  output logic             proto_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  // FSM encoding; the state register itself drives pending, so the state
  // is always observable at the port.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       hold;
  logic       hs;
  logic       viol;
  logic       enter_wait;

  assign hs = valid & master_ready;

  // Next-state and violation detection for the stall tracker.
  always_comb begin
    state_nxt  = state;
    viol       = 1'b0;
    enter_wait = 1'b0;
    case (state)
      IDLE: begin
        if (valid && !master_ready) begin
          state_nxt  = WAIT;
          enter_wait = 1'b1;
        end
      end
      WAIT: begin
        if (!valid) begin
          // Offer withdrawn before the master took it.
          viol      = 1'b1;
          state_nxt = IDLE;
        end else begin
          // Data must stay stable while stalled; a handshake still
          // completes on the same edge even if it changed.
          if (rdata != hold) viol = 1'b1;
          if (master_ready) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; pending is a direct copy of it.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign pending = state[0];

  // Capture the offered bit when a stall begins, for stability checking.
  always_ff @(posedge clk) begin
    if (rst)             hold <= 1'b0;
    else if (enter_wait) hold <= rdata;
  end

  // Transfer datapath: status bit, completion pulse and wrapping counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sin      <= 1'b0;
      xfer     <= 1'b0;
      xfer_cnt <= '0;
    end else if (hs) begin
      sin      <= rdata;
      xfer     <= 1'b1;
      xfer_cnt <= xfer_cnt + CNT_ONE;
    end else begin
      xfer     <= 1'b0;
    end
  end

  // Sticky error flag; a new violation outranks a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst)          proto_err <= 1'b0;
    else if (viol)    proto_err <= 1'b1;
    else if (err_clr) proto_err <= 1'b0;
  end

endmodule

// File: tb/tb_status_flag_blk.sv
// Bench for status_flag_blk: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model and a queue of
// expected transfers.
module tb_status_flag_blk;

  localparam int CNT_W = 2;
  localparam int MOD   = 1 << CNT_W;

  logic             clk;
  logic             rst;
  logic             rdata;
  logic             master_ready;
  logic             valid;
  logic             err_clr;
  logic             sin;
  logic             xfer;
  logic             pending;
  logic             proto_err;
  logic [CNT_W-1:0] xfer_cnt;

  status_flag_blk #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdata        (rdata),
    .master_ready (master_ready),
    .valid        (valid),
    .err_clr      (err_clr),
    .sin          (sin),
    .xfer         (xfer),
    .pending      (pending),
    .proto_err    (proto_err),
    .xfer_cnt     (xfer_cnt)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: an outstanding offer, the bit that was offered, the
  // number of transfers seen so far and the last bit delivered.
  bit m_offer;
  bit m_offer_bit;
  int m_transfers;
  bit m_last_bit;
  bit m_pulse;
  bit m_err;

  // Scoreboard: {bit, count} expected for each completed transfer.
  logic [CNT_W:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit m, input bit d, input bit c);
    bit broke_rule;
    if (r) begin
      m_offer = 0; m_offer_bit = 0; m_transfers = 0;
      m_last_bit = 0; m_pulse = 0; m_err = 0;
      exp_q.delete();
      return;
    end
    // A stalled offer must stay up and unchanged until taken.
    broke_rule = m_offer && (!v || d != m_offer_bit);
    m_pulse = v && m;
    if (m_pulse) begin
      m_transfers++;
      m_last_bit = d;
      exp_q.push_back({d, CNT_W'(m_transfers % MOD)});
    end
    if (broke_rule) m_err = 1;
    else if (c)     m_err = 0;
    if (m_offer) begin
      m_offer = v && !m;
    end else if (v && !m) begin
      m_offer     = 1;
      m_offer_bit = d;
    end
  endtask

  task automatic check_all(input string tag);
    logic [CNT_W:0] e;
    chk({tag, ".sin"},       16'(sin),       16'(m_last_bit));
    chk({tag, ".xfer"},      16'(xfer),      16'(m_pulse));
    chk({tag, ".pending"},   16'(pending),   16'(m_offer));
    chk({tag, ".proto_err"}, 16'(proto_err), 16'(m_err));
    chk({tag, ".xfer_cnt"},  16'(xfer_cnt),  16'(m_transfers % MOD));
    if (xfer === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".sb_spurious"}, 16'(1), 16'(0));
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".sb"}, 16'({sin, xfer_cnt}), 16'(e));
      end
    end
  endtask

  // Driver: apply inputs away from the edge, let the edge happen, then
  // advance the model and compare just after the edge.
  task automatic drive(input string tag, input bit r, input bit v, input bit m,
                       input bit d, input bit c);
    @(negedge clk);
    rst = r; valid = v; master_ready = m; rdata = d; err_clr = c;
    @(posedge clk);
    model_edge(r, v, m, d, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; master_ready = 1'b0; rdata = 1'b0; err_clr = 1'b0;

    // Reset state.
    drive("reset0", 1, 0, 0, 0, 0);
    drive("reset1", 1, 0, 0, 0, 0);

    // Single handshake on the first edge after reset, then idle.
    drive("hs_first", 0, 1, 1, 1, 0);
    drive("hs_idle",  0, 0, 0, 0, 0);

    // Stall for three edges, then complete.
    for (int i = 0; i < 3; i++) drive("stall", 0, 1, 0, 1, 0);
    drive("stall_done", 0, 1, 1, 1, 0);

    // Withdrawn offer, then clear.
    drive("wd_enter", 0, 1, 0, 1, 0);
    drive("wd_drop",  0, 0, 0, 1, 0);
    drive("wd_clr",   0, 0, 0, 0, 1);

    // Data changed during stall, then a run of back-to-back handshakes.
    drive("chg_enter", 0, 1, 0, 1, 0);
    drive("chg_flip",  0, 1, 0, 0, 0);
    for (int i = 0; i < MOD; i++) drive("b2b", 0, 1, 1, 1'($urandom_range(0, 1)), 0);

    // Clear and violation on the same edge: violation wins.
    drive("cv_clr",   0, 0, 0, 0, 1);
    drive("cv_enter", 0, 1, 0, 1, 0);
    drive("cv_both",  0, 1, 0, 0, 1);

    // Reset together with a handshake and a clear.
    drive("rst_hs", 1, 1, 1, 1, 1);

    // master_ready toggling with a constant zero bit.
    for (int i = 0; i < 6; i++) drive("toggle", 0, 1, 1'(i % 2), 0, 0);
    drive("toggle_end", 0, 0, 0, 0, 0);

    // Reset in the middle of a stall.
    drive("mid_enter", 0, 1, 0, 1, 0);
    drive("mid_rst",   1, 1, 0, 1, 0);
    drive("mid_after", 0, 0, 0, 0, 0);

    // Random traffic; stalled offers usually keep their bit stable.
    for (int i = 0; i < 400; i++) begin
      bit r, v, m, d, c;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      m = $urandom_range(0, 1);
      c = ($urandom_range(0, 7) == 0);
      if (m_offer && $urandom_range(0, 3) != 0) d = m_offer_bit;
      else                                      d = $urandom_range(0, 1);
      drive("rand", r, v, m, d, c);
    end

    chk("sb_drained", 16'(exp_q.size()), 16'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/status_flag_blk.md
STATUS_FLAG_BLK -- requirements
Module: status_flag_blk

Interface
REQ-001 Parameter CNT_W, default 8, width of the transfer counter (legal range 2..16).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdata  input  1  read-data status bit offered by the slave side.
REQ-005 master_ready  input  1  master able to accept the status bit.
REQ-006 valid  input  1  rdata is valid and offered for transfer.
REQ-007 err_clr  input  1  synchronous clear of the sticky protocol-error flag.
REQ-008 sin  output  1  registered status-in bit; last rdata value accepted by a handshake.
REQ-009 xfer  output  1  registered one-cycle pulse; a handshake completed on the previous edge.
REQ-010 pending  output  1  high while in WAIT: valid offered, master_ready low.
REQ-011 proto_err  output  1  sticky protocol-violation flag.
REQ-012 xfer_cnt  output  CNT_W  count of completed handshakes, modulo 2^CNT_W.

Function
REQ-013 Handshake: valid=1 and master_ready=1 sampled at a rising edge; valid is ignored while master_ready=0, except for WAIT tracking.
REQ-014 On a handshake edge, sin <= rdata, xfer <= 1, and xfer_cnt <= xfer_cnt+1, wrapping from 2^CNT_W-1 to 0.
REQ-015 On a non-handshake edge, sin holds its value, xfer <= 0, and xfer_cnt holds.
REQ-016 Two-state FSM: IDLE and WAIT; pending is 1 exactly when the state is WAIT.
REQ-017 IDLE -> WAIT when valid=1 and master_ready=0; on entry, rdata is latched into an internal hold register.
REQ-018 IDLE: valid=1 with master_ready=1 is a handshake, and the FSM stays in IDLE.
REQ-019 WAIT -> IDLE on a handshake (valid=1, master_ready=1).
REQ-020 WAIT with valid=1 and master_ready=0 stays in WAIT.
REQ-021 WAIT -> IDLE with valid=0 (offer withdrawn) is a violation: proto_err <= 1, and sin, xfer and xfer_cnt are unaffected.
REQ-022 In WAIT, rdata differing from the hold register while valid=1 is a violation: proto_err <= 1, and the FSM stays in WAIT (or completes the handshake if master_ready=1).
REQ-023 On a WAIT handshake, sin takes the current rdata, not the held value.
REQ-024 proto_err is sticky and clears only on err_clr=1 or reset.
REQ-025 If err_clr=1 and a new violation occur on the same edge, the violation wins and proto_err=1.
REQ-026 Back-to-back handshakes on consecutive edges each count; xfer stays high continuously.
REQ-027 All outputs are driven directly from flops; there is no combinational input-to-output path.

Reset
REQ-028 On a rising edge with rst=1: sin=0, xfer=0, pending=0, proto_err=0, xfer_cnt=0, hold register=0, FSM=IDLE.
REQ-029 rst has priority over every other input, including a handshake and err_clr on the same edge.
REQ-030 Reset asserted mid-WAIT returns the FSM to IDLE with no error recorded.
REQ-031 The first handshake can complete on the first edge after rst deasserts.

Verification
REQ-032 Reset, then rdata=1, master_ready=1, valid=1 for one edge -> next cycle sin=1, xfer=1, xfer_cnt=1; following idle cycle xfer=0, sin=1 held.
REQ-033 valid=1, master_ready=0, rdata=1 for 3 edges -> pending=1, sin unchanged; then master_ready=1 -> sin=1, xfer=1, pending=0, proto_err=0.
REQ-034 Enter WAIT with rdata=1, then drop valid -> proto_err=1, pending=0, xfer_cnt unchanged; err_clr pulse -> proto_err=0.
REQ-035 In WAIT, toggle rdata 1->0 with valid=1 -> proto_err=1; after 2^CNT_W continuous handshakes with CNT_W=2 (4 edges) -> xfer_cnt wraps to 0.
REQ-036 rst=1 together with a handshake and err_clr -> all outputs 0 on the next cycle.
REQ-037 valid=1, rdata=0 with master_ready toggling each edge -> sin=0 after each handshake and xfer_cnt increments every other edge.
